// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, error codes, frame size and parity helper.
// Used by ps2_host_tx and ps2decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [1:0] ERR_NOACK = 2'b01;
    localparam logic [1:0] ERR_WDOG  = 2'b10;
    localparam int PS2_FRAME_BITS    = 11;

    // Odd parity: the returned bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge detect on the clock.
// Lines idle high, so all flops reset to 1 and no false edge appears after reset.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_pin,
    input  logic dat_pin,
    output logic sync_clk,
    output logic sync_dat,
    output logic fall
);
    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       prev_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            prev_clk <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_pin};
            dat_ff   <= {dat_ff[0], dat_pin};
            prev_clk <= clk_ff[1];
        end
    end

    assign sync_clk = clk_ff[1];
    assign sync_dat = dat_ff[1];
    assign fall     = prev_clk & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, then ACK check.
// Defining PS2_TX_WATCHDOG_EN adds an abort timer over BITS/ACK/WAIT_IDLE (err_code 10).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES  = 5000,
    parameter int SETUP_CYCLES    = 250,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [2:0] dbg_state
);
    localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 2);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] phase_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic          dat_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    code_q;
    logic [1:0]    code_next;
    logic          done_set;
    logic          err_set;
    logic          sync_clk;
    logic          sync_dat;
    logic          fall;
    logic          accept;
    logic          wd_expire;

    ps2_line_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .clk_pin  (ps2_clk_in),
        .dat_pin  (ps2_dat_in),
        .sync_clk (sync_clk),
        .sync_dat (sync_dat),
        .fall     (fall)
    );

    // Handshake: a byte moves on any clk edge where tx_valid && tx_ready. tx_ready is high
    // only in IDLE and not while a done/err pulse is showing; tx_valid while busy is ignored.
    assign tx_ready = (state == IDLE) && !done_q && !err_q;
    assign accept   = tx_valid && tx_ready;

`ifdef PS2_TX_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_active;

    assign wd_active = (state == BITS) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (reset || !wd_active) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    assign wd_expire = wd_active && (wd_cnt == WW'(WATCHDOG_CYCLES - 1));
`else
    logic wd_unused;
    assign wd_unused = (WATCHDOG_CYCLES == 0);
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        err_set    = 1'b0;
        code_next  = code_q;
        case (state)
            IDLE:      if (accept) state_next = INHIBIT;
            INHIBIT:   if (phase_cnt == CW'(INHIBIT_CYCLES - 1)) state_next = REQ;
            REQ:       if (phase_cnt == CW'(SETUP_CYCLES - 1)) state_next = BITS;
            BITS:      if (fall && (bit_cnt == LAST_BIT)) state_next = ACK;
            ACK: begin
                if (fall) begin
                    if (!sync_dat) begin
                        state_next = WAIT_IDLE;
                    end else begin
                        state_next = IDLE;
                        err_set    = 1'b1;
                        code_next  = ERR_NOACK;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default:   state_next = IDLE;
        endcase
        if (wd_expire) begin
            state_next = IDLE;
            done_set   = 1'b0;
            err_set    = 1'b1;
            code_next  = ERR_WDOG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            dat_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state  <= state_next;
            done_q <= done_set;
            err_q  <= err_set;
            code_q <= code_next;
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if ((state == INHIBIT) || (state == REQ)) begin
                phase_cnt <= phase_cnt + CW'(1);
            end
            // dat_q starts at 1 so the start bit keeps data low until the first device fall.
            if (accept) begin
                shift   <= {1'b1, odd_parity(tx_data), tx_data};
                dat_q   <= 1'b1;
                bit_cnt <= '0;
            end else if ((state == BITS) && fall) begin
                dat_q   <= ~shift[0];
                shift   <= {1'b0, shift[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign err_code   = code_q;
    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe = (state == REQ) || ((state == BITS) && dat_q);
    assign dbg_state  = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a scoreboard
// checks each done/err pulse against results predicted from the protocol rules.
module tb_ps2_host_tx;

    localparam int INH   = 60;
    localparam int SETUP = 12;
    localparam int WDOG  = 2000;
    localparam int HALF  = 15;
    localparam int LIMIT = 5000;

    localparam int O_NONE  = 0;
    localparam int O_DONE  = 1;
    localparam int O_NOACK = 2;
    localparam int O_WDOG  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [2:0] dbg_state;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int         checks = 0;
    int         fails = 0;
    int         accepts = 0;
    logic       ready_pending = 1'b0;
    logic [1:0] model_code = 2'b00;
    logic [6:0] exp_q[$];
    logic [9:0] exp_frame_q[$];

    // Open-drain bus: a line is low if either end pulls it.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES  (INH),
        .SETUP_CYCLES    (SETUP),
        .WATCHDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / safety stop ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "global timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Expected pulse word: {tx_err, tx_done, err_code, tx_ready, clk_oe, dat_oe}.
    function automatic void push_result(input int outcome);
        case (outcome)
            O_DONE: exp_q.push_back({1'b0, 1'b1, model_code, 3'b000});
            O_NOACK: begin
                model_code = 2'b01;
                exp_q.push_back({1'b1, 1'b0, 2'b01, 3'b000});
            end
            O_WDOG: begin
                model_code = 2'b10;
                exp_q.push_back({1'b1, 1'b0, 2'b10, 3'b000});
            end
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            ready_pending <= 1'b0;
        end else begin
            if (ready_pending) check("ready_after_pulse", 32'(tx_ready), 32'd1);
            ready_pending <= 1'b0;
            if (tx_done || tx_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b code=%0b, expected no pulse",
                             tx_done, tx_err, err_code);
                end else begin
                    check("result", 32'({tx_err, tx_done, err_code, tx_ready, ps2_clk_oe, ps2_dat_oe}),
                          32'(exp_q.pop_front()));
                end
                ready_pending <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) accepts <= accepts + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        check("reset_state", 32'({tx_ready, tx_done, tx_err, err_code, ps2_clk_oe, ps2_dat_oe}),
              32'(7'b1000000));
        reset = 1'b0;
        model_code = 2'b00;
    endtask

    task automatic send(input logic [7:0] d, input int outcome, input bit hold);
        int t;
        t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(t < LIMIT), 32'd1);
        if (outcome == O_DONE || outcome == O_NOACK) exp_frame_q.push_back(model_frame(d));
        push_result(outcome);
        @(posedge clk);
        #1;
        check("ready_drop", 32'(tx_ready), 32'd0);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device model: waits for the released clock with data held low, then clocks n_clocks
    // periods, sampling on each rising edge; the 11th period carries the ACK (data low if ack).
    task automatic device_xfer(input int n_clocks, input bit ack);
        int t;
        logic [9:0] got;
        got = '0;
        t = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && t < LIMIT) begin
            tick(1);
            t++;
        end
        check("rts_seen", 32'(t < LIMIT), 32'd1);
        tick(HALF);
        for (int i = 0; i < n_clocks && i < 10; i++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            got[i] = ps2_dat_in;
            tick(HALF);
        end
        if (n_clocks >= 10) begin
            if (exp_frame_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL frame: got 0x%0h, expected no frame", got);
            end else begin
                check("frame", 32'(got), 32'(exp_frame_q.pop_front()));
            end
        end
        if (n_clocks >= 11) begin
            dev_dat_low = ack;
            tick(3);
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_bits_entry();
        int t;
        t = 0;
        @(negedge clk);
        while (ps2_clk_oe && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("bits_entry", 32'(t < LIMIT), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_inh;
        int n_req;
        int t;
        int a0;
        logic [7:0] d;
        logic [7:0] b2;
        bit ack;

        tick(2);
        do_reset();
        tick(3);

        // 0xED with inhibit/setup timing measured on the outputs
        send(8'hED, O_DONE, 1'b0);
        @(negedge clk);
        n_inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n_inh < LIMIT) begin
            n_inh++;
            @(negedge clk);
        end
        n_req = 0;
        while (ps2_clk_oe && ps2_dat_oe && n_req < LIMIT) begin
            n_req++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n_inh), 32'(INH));
        check("setup_len", 32'(n_req), 32'(SETUP));
        device_xfer(11, 1'b1);

        send(8'hF4, O_DONE, 1'b0);
        device_xfer(11, 1'b1);

        send(8'h00, O_NOACK, 1'b0);
        device_xfer(11, 1'b0);

        for (int k = 0; k < 6; k++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            send(d, ack ? O_DONE : O_NOACK, 1'b0);
            device_xfer(11, ack);
        end

        // tx_valid held high: one accept per ready window, second taken right after tx_done
        a0 = accepts;
        send(8'hAA, O_DONE, 1'b1);
        b2 = 8'($urandom_range(0, 255));
        tx_data = b2;
        exp_frame_q.push_back(model_frame(b2));
        push_result(O_DONE);
        device_xfer(11, 1'b1);
        t = 0;
        @(negedge clk);
        while (!tx_done && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", 32'(t < LIMIT), 32'd1);
        @(negedge clk);
        check("b2b_ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_taken", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        check("accepts_per_window", 32'(accepts - a0), 32'd2);
        device_xfer(11, 1'b1);
        tick(5);

        // device never clocks
`ifdef PS2_TX_WATCHDOG_EN
        send(8'h5A, O_WDOG, 1'b0);
        wait_bits_entry();
        t = 0;
        while (!tx_err && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("wdog_latency", 32'(t), 32'(WDOG));
        tick(3);
`else
        send(8'h5A, O_NONE, 1'b0);
        wait_bits_entry();
        repeat (3000) @(negedge clk);
        check("stall_hold", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_err}), 32'(5'b01000));
        tick(1);
        do_reset();
`endif

        // reset after the 4th fall of 0xFF, then a fresh 0x01
        send(8'hFF, O_NONE, 1'b0);
        device_xfer(4, 1'b0);
        do_reset();
        tick(10);
        send(8'h01, O_DONE, 1'b0);
        device_xfer(11, 1'b1);

        tick(20);
        check("results_drained", 32'(exp_q.size()), 32'd0);
        check("frames_drained", 32'(exp_frame_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
